alu_issue_stage: RTL and testbench

Two-stage operand-issue and writeback wrapper around the 32-bit combinational ALU. Accepts register-form or immediate-form instructions over a valid/ready handshake, reads operands from a 16-entry register file with full forwarding, and drives the ALU's A/B/Fin inputs from a pipeline register. It captures the ALU's Y/Cout into a writeback register and retires results to the register file and a carry flag. The ALU instance sits outside this block; this block is its direct upstream feeder and downstream consumer.

---
 rtl/alu_issue_stage_pkg.sv | 29 ++
 rtl/alu_regfile.sv | 46 ++++
 rtl/alu_issue_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU and its issue/writeback wrapper.
// Holds the 4-bit ALU function codes, the datapath width and the
// instruction field widths. No ports; imported by alu_regfile and
// alu_issue_stage.
package alu_issue_stage_pkg;

   localparam int unsigned DataW = 32;  // operand/result width
   localparam int unsigned AddrW = 4;   // register index width
   localparam int unsigned FnW   = 4;   // function code width
   localparam int unsigned ImmW  = 16;  // immediate width

   localparam logic [FnW-1:0] FnAnd    = 4'd0;
   localparam logic [FnW-1:0] FnOr     = 4'd1;
   localparam logic [FnW-1:0] FnAdd    = 4'd2;
   localparam logic [FnW-1:0] FnUnused = 4'd3;
   localparam logic [FnW-1:0] FnAndi   = 4'd4;
   localparam logic [FnW-1:0] FnOri    = 4'd5;
   localparam logic [FnW-1:0] FnSub    = 4'd6;
   localparam logic [FnW-1:0] FnSlt    = 4'd7;
   localparam logic [FnW-1:0] FnXor    = 4'd8;
   localparam logic [FnW-1:0] FnXnor   = 4'd9;
   localparam logic [FnW-1:0] FnLsl    = 4'd10;
   localparam logic [FnW-1:0] FnLsr    = 4'd11;
   localparam logic [FnW-1:0] FnSat    = 4'd12;
   localparam logic [FnW-1:0] FnAsr    = 4'd13;
   localparam logic [FnW-1:0] FnRl     = 4'd14;
   localparam logic [FnW-1:0] FnRr     = 4'd15;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue stage.
// 2^ADDR_W x DATA_W storage, register 0 hard-wired to zero.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears all entries)
//   rs_addr_i/rs_data_o   combinational read port A
//   rt_addr_i/rt_data_o   combinational read port B
//   dbg_addr_i/dbg_data_o combinational debug read port
//   we_i, wr_addr_i, wr_data_i  synchronous write port
module alu_regfile
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataW,
   parameter int unsigned ADDR_W = AddrW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rt_data_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (wr_addr_i != '0)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rs_data_o  = (rs_addr_i  == '0) ? '0 : mem_q[rs_addr_i];
   assign rt_data_o  = (rt_addr_i  == '0) ? '0 : mem_q[rt_addr_i];
   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage operand-issue / writeback wrapper around the external ALU.
// IS stage registers the ALU operands and function code; WB stage captures
// the ALU result and retires it to the register file and the carry flag.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               instruction handshake
//   in_fn, in_rd, in_rs, in_rt      function code and register indices
//   in_use_imm, in_imm              immediate-form select and 16-bit immediate
//   alu_a, alu_b, alu_fn            registered ALU inputs
//   alu_y, alu_cout                 combinational ALU result
//   wb_valid/wb_ready               writeback handshake
//   wb_rd, wb_data, wb_cout         retiring result
//   carry_flag                      carry of the last retired instruction
//   dbg_addr, dbg_data              register-file peek, no forwarding
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataW,
   parameter int unsigned ADDR_W = AddrW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FnW-1:0]    in_fn,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic              in_use_imm,
   input  logic [ImmW-1:0]   in_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [FnW-1:0]    alu_fn,
   input  logic [DATA_W-1:0] alu_y,
   input  logic              alu_cout,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_cout,
   output logic              carry_flag,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   // IS stage
   logic              is_valid_q;
   logic [ADDR_W-1:0] is_rd_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q;
   logic [FnW-1:0]    alu_fn_q;
   // WB stage
   logic              wb_valid_q;
   logic [ADDR_W-1:0] wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              wb_cout_q;
   logic              carry_flag_q;

   logic              wb_adv, is_adv, retire;
   logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
   logic [DATA_W-1:0] op_a_d, op_b_d;

   assign wb_adv   = !wb_valid_q || wb_ready;
   assign is_adv   = !is_valid_q || wb_adv;
   assign in_ready = is_adv;
   assign retire   = wb_valid_q && wb_ready;

   alu_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs_addr_i  (in_rs),
      .rs_data_o  (rf_rs_data),
      .rt_addr_i  (in_rt),
      .rt_data_o  (rf_rt_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (retire),
      .wr_addr_i  (wb_rd_q),
      .wr_data_i  (wb_data_q)
   );

   // Youngest producer wins; the WB forward also covers a same-cycle retire,
   // so the register file needs no write-first bypass.
   function automatic logic [DATA_W-1:0] fwd_operand(
      input logic [ADDR_W-1:0] s,
      input logic [DATA_W-1:0] rf_data,
      input logic              is_v,
      input logic [ADDR_W-1:0] is_rd,
      input logic [DATA_W-1:0] is_y,
      input logic              wb_v,
      input logic [ADDR_W-1:0] wb_rd_i,
      input logic [DATA_W-1:0] wb_y
   );
      logic [DATA_W-1:0] r;
      if (s == '0)                     r = '0;
      else if (is_v && (is_rd == s))   r = is_y;
      else if (wb_v && (wb_rd_i == s)) r = wb_y;
      else                             r = rf_data;
      return r;
   endfunction

   always_comb begin
      op_a_d = fwd_operand(in_rs, rf_rs_data, is_valid_q, is_rd_q, alu_y,
                           wb_valid_q, wb_rd_q, wb_data_q);
      op_b_d = fwd_operand(in_rt, rf_rt_data, is_valid_q, is_rd_q, alu_y,
                           wb_valid_q, wb_rd_q, wb_data_q);
      if (in_use_imm) begin
         op_b_d = DATA_W'(in_imm);
      end
   end

   // Payload registers load only with a valid entry so that alu_* and wb_*
   // do not wander while a stage is empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         is_valid_q   <= 1'b0;
         is_rd_q      <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_fn_q     <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         wb_cout_q    <= 1'b0;
         carry_flag_q <= 1'b0;
      end else begin
         if (is_adv) begin
            is_valid_q <= in_valid;
            if (in_valid) begin
               is_rd_q  <= in_rd;
               alu_a_q  <= op_a_d;
               alu_b_q  <= op_b_d;
               alu_fn_q <= in_fn;
            end
         end
         if (wb_adv) begin
            wb_valid_q <= is_valid_q;
            if (is_valid_q) begin
               wb_rd_q   <= is_rd_q;
               wb_data_q <= alu_y;
               wb_cout_q <= alu_cout;
            end
         end
         if (retire) begin
            carry_flag_q <= wb_cout_q;
         end
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_fn     = alu_fn_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign wb_cout    = wb_cout_q;
   assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU stand-in.
module tb_alu_issue_stage;
   import alu_issue_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_fn;
   logic [3:0]  in_rd, in_rs, in_rt;
   logic        in_use_imm;
   logic [15:0] in_imm;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_fn;
   logic [31:0] alu_y;
   logic        alu_cout;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_cout;
   logic        carry_flag;
   logic [3:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fn      (in_fn),
      .in_rd      (in_rd),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fn     (alu_fn),
      .alu_y      (alu_y),
      .alu_cout   (alu_cout),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_cout    (wb_cout),
      .carry_flag (carry_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // ALU stand-in: only the operations the vectors use.
   always_comb begin
      alu_y    = '0;
      alu_cout = 1'b0;
      case (alu_fn)
         FnAnd: alu_y = alu_a & alu_b;
         FnOr:  alu_y = alu_a | alu_b;
         FnAdd: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
         FnSub: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
         default: alu_y = '0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] fn, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [3:0] rt, input logic use_imm, input logic [15:0] imm);
      in_valid   = 1'b1;
      in_fn      = fn;
      in_rd      = rd;
      in_rs      = rs;
      in_rt      = rt;
      in_use_imm = use_imm;
      in_imm     = imm;
   endtask

   task automatic peek(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      #1;
      check_eq(tag, dbg_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1; dbg_addr = '0;
      in_fn = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_use_imm = 1'b0; in_imm = '0;
      step(); step();
      rst_n = 1'b1;

      // Reset state
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
      check_eq("rst_alu_a", alu_a, 32'd0);
      check_eq("rst_alu_b", alu_b, 32'd0);
      check_eq("rst_alu_fn", 32'(alu_fn), 32'd0);
      check_eq("rst_wb_data", wb_data, 32'd0);
      check_eq("rst_carry", 32'(carry_flag), 32'd0);

      // Basic immediate ADD: r1 = 0 + 5
      drive(FnAdd, 4'd1, 4'd0, 4'd0, 1'b1, 16'd5);
      step();
      in_valid = 1'b0;
      check_eq("t1_alu_a", alu_a, 32'd0);
      check_eq("t1_alu_b", alu_b, 32'd5);
      check_eq("t1_alu_fn", 32'(alu_fn), 32'h2);
      step();
      check_eq("t1_wb_valid", 32'(wb_valid), 32'd1);
      check_eq("t1_wb_data", wb_data, 32'd5);
      check_eq("t1_wb_rd", 32'(wb_rd), 32'd1);
      step();
      peek("t1_r1", 4'd1, 32'd5);

      // Back-to-back forwarding: r1=7, r2=r1+r1, r3=r2-r1
      drive(FnAdd, 4'd1, 4'd0, 4'd0, 1'b1, 16'd7);
      check_eq("t2_ready0", 32'(in_ready), 32'd1);
      step();
      drive(FnAdd, 4'd2, 4'd1, 4'd1, 1'b0, 16'd0);
      check_eq("t2_ready1", 32'(in_ready), 32'd1);
      step();
      check_eq("t2_a1", alu_a, 32'd7);
      check_eq("t2_b1", alu_b, 32'd7);
      drive(FnSub, 4'd3, 4'd2, 4'd1, 1'b0, 16'd0);
      check_eq("t2_ready2", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check_eq("t2_a2", alu_a, 32'd14);
      check_eq("t2_b2", alu_b, 32'd7);
      check_eq("t2_fn2", 32'(alu_fn), 32'h6);
      step(); step(); step();
      peek("t2_r1", 4'd1, 32'd7);
      peek("t2_r2", 4'd2, 32'd14);
      peek("t2_r3", 4'd3, 32'd7);

      // Backpressure: r5=3, r6=r5+r5, r7=r6-r5 with wb_ready low
      wb_ready = 1'b0;
      drive(FnAdd, 4'd5, 4'd0, 4'd0, 1'b1, 16'd3);
      check_eq("t3_ready0", 32'(in_ready), 32'd1);
      step();
      drive(FnAdd, 4'd6, 4'd5, 4'd5, 1'b0, 16'd0);
      check_eq("t3_ready1", 32'(in_ready), 32'd1);
      step();
      drive(FnSub, 4'd7, 4'd6, 4'd5, 1'b0, 16'd0);
      check_eq("t3_ready_full", 32'(in_ready), 32'd0);
      check_eq("t3_wb_data0", wb_data, 32'd3);
      check_eq("t3_wb_rd0", 32'(wb_rd), 32'd5);
      step();
      check_eq("t3_ready_held", 32'(in_ready), 32'd0);
      check_eq("t3_wb_data_held", wb_data, 32'd3);
      check_eq("t3_wb_rd_held", 32'(wb_rd), 32'd5);
      check_eq("t3_a_held", alu_a, 32'd3);
      check_eq("t3_b_held", alu_b, 32'd3);
      peek("t3_r5_not_retired", 4'd5, 32'd0);
      wb_ready = 1'b1;
      #1;
      check_eq("t3_ready_release", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check_eq("t3_a3", alu_a, 32'd6);
      check_eq("t3_b3", alu_b, 32'd3);
      check_eq("t3_wb_data1", wb_data, 32'd6);
      check_eq("t3_wb_rd1", 32'(wb_rd), 32'd6);
      step();
      check_eq("t3_wb_data2", wb_data, 32'd3);
      check_eq("t3_wb_rd2", 32'(wb_rd), 32'd7);
      step(); step();
      peek("t3_r5", 4'd5, 32'd3);
      peek("t3_r6", 4'd6, 32'd6);
      peek("t3_r7", 4'd7, 32'd3);

      // Carry: r1 = 0 - 1, r2 = r1 + 1, then AND clears carry
      drive(FnSub, 4'd1, 4'd0, 4'd0, 1'b1, 16'd1);
      step();
      drive(FnAdd, 4'd2, 4'd1, 4'd0, 1'b1, 16'd1);
      step();
      in_valid = 1'b0;
      check_eq("t4_a", alu_a, 32'hFFFF_FFFF);
      step();
      check_eq("t4_wb_data", wb_data, 32'd0);
      check_eq("t4_wb_cout", 32'(wb_cout), 32'd1);
      step();
      check_eq("t4_carry_set", 32'(carry_flag), 32'd1);
      drive(FnAnd, 4'd3, 4'd1, 4'd1, 1'b0, 16'd0);
      step();
      in_valid = 1'b0;
      step(); step();
      check_eq("t4_carry_clr", 32'(carry_flag), 32'd0);
      peek("t4_r1", 4'd1, 32'hFFFF_FFFF);
      peek("t4_r3", 4'd3, 32'hFFFF_FFFF);

      // r0 guard: r0 = r1 + 9 (carry out), then r4 = r0 + 2
      drive(FnAdd, 4'd0, 4'd1, 4'd0, 1'b1, 16'd9);
      step();
      drive(FnAdd, 4'd4, 4'd0, 4'd0, 1'b1, 16'd2);
      step();
      in_valid = 1'b0;
      check_eq("t5_a_no_fwd", alu_a, 32'd0);
      check_eq("t5_b", alu_b, 32'd2);
      check_eq("t5_wb_data", wb_data, 32'd8);
      step();
      check_eq("t5_carry_r0", 32'(carry_flag), 32'd1);
      peek("t5_r0", 4'd0, 32'd0);
      step();
      check_eq("t5_carry_r4", 32'(carry_flag), 32'd0);
      peek("t5_r4", 4'd4, 32'd2);

      // Reset mid-stream with both stages valid
      wb_ready = 1'b0;
      drive(FnAdd, 4'd9, 4'd0, 4'd0, 1'b1, 16'd11);
      step();
      drive(FnAdd, 4'd10, 4'd0, 4'd0, 1'b1, 16'd12);
      step();
      check_eq("t6_wb_valid_pre", 32'(wb_valid), 32'd1);
      drive(FnAdd, 4'd11, 4'd0, 4'd0, 1'b1, 16'd13);
      rst_n    = 1'b0;
      wb_ready = 1'b1;
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check_eq("t6_wb_valid", 32'(wb_valid), 32'd0);
      check_eq("t6_wb_data", wb_data, 32'd0);
      check_eq("t6_wb_rd", 32'(wb_rd), 32'd0);
      check_eq("t6_wb_cout", 32'(wb_cout), 32'd0);
      check_eq("t6_alu_a", alu_a, 32'd0);
      check_eq("t6_in_ready", 32'(in_ready), 32'd1);
      step();
      check_eq("t6_wb_valid_post", 32'(wb_valid), 32'd0);
      peek("t6_r9", 4'd9, 32'd0);
      peek("t6_r10", 4'd10, 32'd0);
      peek("t6_r4_cleared", 4'd4, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
